// File: rtl/data_ram_responder.sv
// Single-port 32-bit data RAM answering an active-low SRAM-style bus, split into per-byte lanes.
// Optional DATA_RAM_STATS_EN builds saturating read/write access counters.

module data_ram_lane #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr,
  input  logic              rd,
  input  logic              en,
  input  logic [ADDR_W-1:0] idx,
  input  logic [7:0]        wdata,
  output logic [7:0]        rdata
);
  logic [7:0] mem [2**ADDR_W];

  // Reset only gates the write so an edge seen while reset is low drops it;
  // the array contents themselves are never cleared.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
    end else if (wr && en) begin
      mem[idx] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (rd) rdata <= en ? mem[idx] : 8'h00;
  end
endmodule

module data_ram_responder #(
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ram_ce_n,
  input  logic        ram_we_n,
  input  logic        ram_oe_n,
  input  logic [3:0]  ram_byte_en_n,
  input  logic [31:0] ram_addr,
  inout  wire  [31:0] ram_data,
  output logic        range_err,
  output logic [31:0] rd_count,
  output logic [31:0] wr_count
);
  localparam int NUM_LANES = 4;

  typedef struct packed {
    logic              rd;
    logic              wr;
    logic              in_range;
    logic [ADDR_W-1:0] idx;
  } req_t;

  req_t                        req;
  logic [31:0]                 off;
  logic [NUM_LANES-1:0][7:0]   rdata_q;
  logic [NUM_LANES-1:0][7:0]   wdata;
  logic                        unused_off;

  assign off        = ram_addr - BASE_ADDR;
  assign unused_off = ^off[1:0];
  assign wdata      = ram_data;

  always_comb begin
    req          = '0;
    req.wr       = !ram_ce_n && !ram_we_n;
    req.rd       = !ram_ce_n &&  ram_we_n && !ram_oe_n;
    req.in_range = (off[31:ADDR_W+2] == '0);
    req.idx      = off[ADDR_W+1:2];
  end

  // Write wins over output enable, so the bus is only driven on a pure read.
  assign ram_data = req.rd ? rdata_q : 32'hzzzz_zzzz;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    data_ram_lane #(.ADDR_W(ADDR_W)) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .wr    (req.wr),
      .rd    (req.rd),
      .en    (req.in_range && !ram_byte_en_n[i]),
      .idx   (req.idx),
      .wdata (wdata[i]),
      .rdata (rdata_q[i])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                   range_err <= 1'b0;
    else if ((req.rd || req.wr) && !req.in_range) range_err <= 1'b1;
  end

`ifdef DATA_RAM_STATS_EN
  logic [31:0] rd_cnt_q, wr_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_cnt_q <= '0;
      wr_cnt_q <= '0;
    end else begin
      if (req.rd && rd_cnt_q != '1) rd_cnt_q <= rd_cnt_q + 32'd1;
      if (req.wr && wr_cnt_q != '1) wr_cnt_q <= wr_cnt_q + 32'd1;
    end
  end

  assign rd_count = rd_cnt_q;
  assign wr_count = wr_cnt_q;
`else
  assign rd_count = 32'h0;
  assign wr_count = 32'h0;
`endif
endmodule

// File: tb/tb_data_ram_responder.sv
// Self-checking bench for data_ram_responder: directed scenarios plus a randomized
// byte-masked write/read mix checked against a word-level model.

module tb_data_ram_responder;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        ce_n, we_n, oe_n;
  logic [3:0]  be_n;
  logic [31:0] addr;
  logic [31:0] drv;
  logic        drv_en;
  wire  [31:0] ram_data;
  logic        range_err;
  logic [31:0] rd_count, wr_count;

  int errs   = 0;
  int checks = 0;

  logic [31:0] mdl [int];

  assign ram_data = drv_en ? drv : 32'hzzzz_zzzz;

  always #5 clk = ~clk;

  data_ram_responder #(.ADDR_W(10), .BASE_ADDR(32'h0)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ram_ce_n      (ce_n),
    .ram_we_n      (we_n),
    .ram_oe_n      (oe_n),
    .ram_byte_en_n (be_n),
    .ram_addr      (addr),
    .ram_data      (ram_data),
    .range_err     (range_err),
    .rd_count      (rd_count),
    .wr_count      (wr_count)
  );

  function automatic logic [31:0] lane_mask(input logic [3:0] b);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) m[8*i +: 8] = b[i] ? 8'h00 : 8'hFF;
    return m;
  endfunction

  task automatic idle();
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b1; drv_en = 1'b0;
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = a; be_n = b; drv = d; drv_en = 1'b1;
    @(posedge clk); #1;
    idle();
  endtask

  task automatic do_read(input logic [31:0] a, input logic [3:0] b, input int n,
                         output logic [31:0] d);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = a; be_n = b; drv_en = 1'b0;
    repeat (n) @(posedge clk);
    #1;
    d = ram_data;
    idle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; be_n = 4'h0; addr = '0; drv_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (ram_data !== 32'h0) begin errs++; $display("FAIL reset_bus got=%h exp=0", ram_data); end
    checks++; if (range_err !== 1'b0) begin errs++; $display("FAIL reset_err got=%b exp=0", range_err); end
    checks++; if (rd_count !== 32'h0 || wr_count !== 32'h0) begin
      errs++; $display("FAIL reset_counts rd=%h wr=%h exp=0", rd_count, wr_count);
    end
    ce_n = 1'b1; rst_n = 1'b1; drv = 32'h5A5A_C3C3; drv_en = 1'b1; #1;
    checks++; if (ram_data !== 32'h5A5A_C3C3) begin errs++; $display("FAIL reset_release got=%h exp=5a5ac3c3", ram_data); end
    idle();
    @(posedge clk); #1;
  endtask

  task automatic test_word_and_mask();
    logic [31:0] d;
    do_write(32'h10, 32'hDEAD_BEEF, 4'b0000);
    do_read(32'h10, 4'b0000, 2, d);
    checks++; if (d !== 32'hDEAD_BEEF) begin errs++; $display("FAIL full_word got=%h exp=deadbeef", d); end
    do_write(32'h10, 32'h1122_3344, 4'b1010);
    do_read(32'h10, 4'b0000, 2, d);
    checks++; if (d !== 32'hDE22_BE44) begin errs++; $display("FAIL byte_write got=%h exp=de22be44", d); end
    do_read(32'h10, 4'b0011, 2, d);
    checks++; if (d !== 32'hDE22_0000) begin errs++; $display("FAIL byte_read got=%h exp=de220000", d); end
  endtask

  task automatic test_contention();
    logic [31:0] d;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b0; addr = 32'h10; be_n = 4'h0; drv = 32'hA5A5_A5A5; drv_en = 1'b1;
    #1;
    checks++; if (ram_data !== 32'hA5A5_A5A5) begin errs++; $display("FAIL contention_bus got=%h exp=a5a5a5a5", ram_data); end
    @(posedge clk); #1;
    idle();
    do_read(32'h10, 4'b0000, 2, d);
    checks++; if (d !== 32'hA5A5_A5A5) begin errs++; $display("FAIL contention_write got=%h exp=a5a5a5a5", d); end
    ce_n = 1'b1; we_n = 1'b1; oe_n = 1'b0; drv = 32'h0F0F_1234; drv_en = 1'b1; #1;
    checks++; if (ram_data !== 32'h0F0F_1234) begin errs++; $display("FAIL ce_release got=%h exp=0f0f1234", ram_data); end
    idle();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d;
    do_write(32'h30, 32'h1357_9BDF, 4'h0);
    do_write(32'h34, 32'h2468_ACE0, 4'h0);
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; be_n = 4'h0; addr = 32'h30; drv_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    addr = 32'h34; #1;
    checks++; if (ram_data !== 32'h1357_9BDF) begin errs++; $display("FAIL b2b_stale got=%h exp=13579bdf", ram_data); end
    @(posedge clk); #1;
    checks++; if (ram_data !== 32'h2468_ACE0) begin errs++; $display("FAIL b2b_new got=%h exp=2468ace0", ram_data); end
    idle();
    // Read the word written in the previous cycle.
    do_write(32'h30, 32'h0BAD_CAFE, 4'h0);
    do_read(32'h30, 4'h0, 2, d);
    checks++; if (d !== 32'h0BAD_CAFE) begin errs++; $display("FAIL raw got=%h exp=0badcafe", d); end
  endtask

  task automatic test_range();
    logic [31:0] d;
    do_write(32'h0, 32'h600D_F00D, 4'h0);
    checks++; if (range_err !== 1'b0) begin errs++; $display("FAIL range_pre got=%b exp=0", range_err); end
    do_write(32'h1000, 32'hFFFF_FFFF, 4'h0);
    checks++; if (range_err !== 1'b1) begin errs++; $display("FAIL range_set got=%b exp=1", range_err); end
    do_read(32'h0, 4'h0, 2, d);
    checks++; if (d !== 32'h600D_F00D) begin errs++; $display("FAIL range_nowrite got=%h exp=600df00d", d); end
    do_read(32'h1000, 4'h0, 2, d);
    checks++; if (d !== 32'h0) begin errs++; $display("FAIL range_read got=%h exp=0", d); end
    checks++; if (range_err !== 1'b1) begin errs++; $display("FAIL range_sticky got=%b exp=1", range_err); end
  endtask

  task automatic test_mid_reset();
    logic [31:0] d;
    do_write(32'h20, 32'h1234_5678, 4'h0);
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 32'h20; be_n = 4'h0; drv = 32'hCAFE_F00D; drv_en = 1'b1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    idle(); rst_n = 1'b1;
    checks++; if (range_err !== 1'b0) begin errs++; $display("FAIL midrst_err got=%b exp=0", range_err); end
    do_read(32'h20, 4'h0, 2, d);
    checks++; if (d !== 32'h1234_5678) begin errs++; $display("FAIL midrst_drop got=%h exp=12345678", d); end
    ce_n = 1'b0; we_n = 1'b1; oe_n = 1'b0; addr = 32'h20;
    @(posedge clk); #1;
    rst_n = 1'b0; #1;
    checks++; if (ram_data !== 32'h0) begin errs++; $display("FAIL midrst_rdata got=%h exp=0", ram_data); end
    idle(); rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_random();
    int          idxs[$];
    logic [31:0] d, a, w, exp;
    logic [3:0]  b;
    int          k;
    for (int i = 0; i < 12; i++) begin
      k = $urandom_range(1, 1023);
      idxs.push_back(k);
      w = $urandom;
      do_write(k * 4, w, 4'h0);
      mdl[k] = w;
    end
    for (int i = 0; i < 40; i++) begin
      k = idxs[$urandom_range(0, idxs.size() - 1)];
      a = k * 4 + $urandom_range(0, 3);
      w = $urandom;
      b = 4'($urandom);
      if ($urandom_range(0, 7) == 0) begin
        do_write(a + 32'h1000 * $urandom_range(1, 4), w, b);
      end else begin
        do_write(a, w, b);
        mdl[k] = (mdl[k] & ~lane_mask(b)) | (w & lane_mask(b));
      end
      k = idxs[$urandom_range(0, idxs.size() - 1)];
      b = 4'($urandom);
      do_read(k * 4, b, 2, d);
      exp = mdl[k] & lane_mask(b);
      checks++; if (d !== exp) begin errs++; $display("FAIL rand_read idx=%0d got=%h exp=%h", k, d, exp); end
    end
    checks++; if (range_err !== 1'b1) begin errs++; $display("FAIL rand_err got=%b exp=1", range_err); end
  endtask

  task automatic test_stats();
    logic [31:0] d;
    logic [31:0] exp_rd, exp_wr;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    @(posedge clk); #1;
    ce_n = 1'b0; we_n = 1'b0; oe_n = 1'b1; addr = 32'h40; be_n = 4'h0; drv = 32'h7777_1111; drv_en = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    idle();
    do_read(32'h40, 4'h0, 5, d);
`ifdef DATA_RAM_STATS_EN
    exp_rd = 32'd5; exp_wr = 32'd3;
`else
    exp_rd = 32'd0; exp_wr = 32'd0;
`endif
    checks++; if (wr_count !== exp_wr) begin errs++; $display("FAIL wr_count got=%h exp=%h", wr_count, exp_wr); end
    checks++; if (rd_count !== exp_rd) begin errs++; $display("FAIL rd_count got=%h exp=%h", rd_count, exp_rd); end
`ifdef DATA_RAM_STATS_EN
    force dut.rd_cnt_q = 32'hFFFF_FFFE;
    #1;
    release dut.rd_cnt_q;
    do_read(32'h40, 4'h0, 3, d);
    checks++; if (rd_count !== 32'hFFFF_FFFF) begin errs++; $display("FAIL rd_sat got=%h exp=ffffffff", rd_count); end
`endif
  endtask

  initial begin
    idle();
    addr = '0; be_n = 4'h0; drv = '0;
    test_reset();
    test_word_and_mask();
    test_contention();
    test_back_to_back();
    test_range();
    test_mid_reset();
    test_random();
    test_stats();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
